// File: rtl/nibble_exec.sv
// =============================================================================
// Module   : nibble_exec
// Brief    : 4-bit accumulator execute stage with two-byte jumps and halt.
// Revision : 1.0
// =============================================================================
`default_nettype none

module nibble_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  instr,
    input  logic [3:0]  oprnd,
    input  logic        in_valid,
    input  logic [3:0]  data_in,
    output logic [3:0]  acc,
    output logic        carry,
    output logic        zero,
    output logic [3:0]  data_out,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [11:0] pc_target,
    output logic        halt
);

    localparam logic [1:0] c_EXEC = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_acc;
    logic [3:0]  r_dataOut;
    logic [3:0]  r_tgtHi;
    logic        r_carry;
    logic        r_zero;
    logic        r_pcInc;
    logic        r_pcLoad;
    logic        r_taken;
    logic [11:0] r_pcTarget;

    logic [4:0]  w_sum;
    logic [4:0]  w_diff;
    logic [3:0]  w_aluRes;
    logic        w_accWr;
    logic        w_zeroWr;
    logic        w_carryWr;
    logic        w_carryVal;
    logic        w_isJump;
    logic        w_jmpTaken;

    // Bit 4 of the 5-bit difference is the borrow, i.e. acc < oprnd.
    assign w_sum  = {1'b0, r_acc} + {1'b0, oprnd};
    assign w_diff = {1'b0, r_acc} - {1'b0, oprnd};

    assign w_isJump   = (instr == 4'hB) || (instr == 4'hC) || (instr == 4'hD);
    assign w_jmpTaken = (instr == 4'hB) || ((instr == 4'hC) && r_zero) ||
                        ((instr == 4'hD) && r_carry);

    always_comb begin
        w_aluRes   = r_acc;
        w_accWr    = 1'b0;
        w_zeroWr   = 1'b0;
        w_carryWr  = 1'b0;
        w_carryVal = r_carry;
        case (instr)
            4'h1: begin w_aluRes = oprnd;         w_accWr = 1'b1; w_zeroWr = 1'b1; end
            4'h2: begin
                w_aluRes = w_sum[3:0];  w_accWr = 1'b1; w_zeroWr = 1'b1;
                w_carryWr = 1'b1;       w_carryVal = w_sum[4];
            end
            4'h3: begin
                w_aluRes = w_diff[3:0]; w_accWr = 1'b1; w_zeroWr = 1'b1;
                w_carryWr = 1'b1;       w_carryVal = w_diff[4];
            end
            4'h4: begin w_aluRes = r_acc & oprnd; w_accWr = 1'b1; w_zeroWr = 1'b1; end
            4'h5: begin w_aluRes = r_acc | oprnd; w_accWr = 1'b1; w_zeroWr = 1'b1; end
            4'h6: begin w_aluRes = r_acc ^ oprnd; w_accWr = 1'b1; w_zeroWr = 1'b1; end
            4'h7: begin w_aluRes = ~r_acc;        w_accWr = 1'b1; w_zeroWr = 1'b1; end
            4'h8: begin w_aluRes = data_in;       w_accWr = 1'b1; w_zeroWr = 1'b1; end
            // CMP: flags from the subtraction, accumulator untouched.
            4'hA: begin
                w_aluRes = w_diff[3:0]; w_zeroWr = 1'b1;
                w_carryWr = 1'b1;       w_carryVal = w_diff[4];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_EXEC;
            r_acc      <= 4'h0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_dataOut  <= 4'h0;
            r_pcInc    <= 1'b0;
            r_pcLoad   <= 1'b0;
            r_pcTarget <= 12'h000;
            r_tgtHi    <= 4'h0;
            r_taken    <= 1'b0;
        end else begin
            r_pcInc  <= 1'b0;
            r_pcLoad <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    c_EXEC: begin
                        if (w_accWr)   r_acc   <= w_aluRes;
                        if (w_zeroWr)  r_zero  <= (w_aluRes == 4'h0);
                        if (w_carryWr) r_carry <= w_carryVal;
                        if (instr == 4'h9) r_dataOut <= r_acc;
                        if (instr == 4'hF) begin
                            r_state <= c_HALT;
                        end else begin
                            r_pcInc <= 1'b1;
                            if (w_isJump) begin
                                r_tgtHi <= oprnd;
                                r_taken <= w_jmpTaken;
                                r_state <= c_ADDR;
                            end
                        end
                    end
                    c_ADDR: begin
                        r_pcTarget <= {r_tgtHi, instr, oprnd};
                        r_pcLoad   <= r_taken;
                        r_pcInc    <= ~r_taken;
                        r_state    <= c_EXEC;
                    end
                    c_HALT: ;
                    default: r_state <= c_EXEC;
                endcase
            end
        end
    end

    assign acc       = r_acc;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign data_out  = r_dataOut;
    assign pc_inc    = r_pcInc;
    assign pc_load   = r_pcLoad;
    assign pc_target = r_pcTarget;
    assign halt      = (r_state == c_HALT);

endmodule

`default_nettype wire

// File: tb/tb_nibble_exec.sv
// =============================================================================
// Module   : tb_nibble_exec
// Brief    : Self-checking bench for nibble_exec against a behavioural model.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_nibble_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  instr, oprnd, dataIn;
    logic        inValid;
    logic [3:0]  acc, dataOut;
    logic        carry, zero, pcInc, pcLoad, halt;
    logic [11:0] pcTarget;

    int checks   = 0;
    int failures = 0;

    // Reference model state: mode 0 = executing, 1 = awaiting address byte, 2 = halted.
    int          mMode;
    logic [3:0]  mAcc, mOut, mHi;
    logic        mC, mZ, mInc, mLoad, mTaken;
    logic [11:0] mTgt;

    nibble_exec dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .oprnd    (oprnd),
        .in_valid (inValid),
        .data_in  (dataIn),
        .acc      (acc),
        .carry    (carry),
        .zero     (zero),
        .data_out (dataOut),
        .pc_inc   (pcInc),
        .pc_load  (pcLoad),
        .pc_target(pcTarget),
        .halt     (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] obsVec();
        return {acc, carry, zero, dataOut, pcInc, pcLoad, pcTarget, halt};
    endfunction

    function automatic logic [24:0] expVec();
        return {mAcc, mC, mZ, mOut, mInc, mLoad, mTgt, (mMode == 2)};
    endfunction

    task automatic modelReset();
        mMode = 0; mAcc = 0; mOut = 0; mHi = 0; mC = 0; mZ = 0;
        mInc = 0; mLoad = 0; mTaken = 0; mTgt = 0;
    endtask

    task automatic modelStep(input bit v, input logic [3:0] i, input logic [3:0] o,
                             input logic [3:0] d);
        int a, r;
        mInc = 0; mLoad = 0;
        if (!v || mMode == 2) return;
        if (mMode == 1) begin
            mTgt = {mHi, i, o}; mLoad = mTaken; mInc = !mTaken; mMode = 0;
            return;
        end
        a = int'(mAcc);
        mInc = 1;
        case (i)
            4'h1: begin mAcc = o; mZ = (o == 0); end
            4'h2: begin r = a + int'(o); mC = (r > 15); mAcc = 4'(r % 16); mZ = (r % 16 == 0); end
            4'h3: begin r = (a - int'(o) + 16) % 16; mC = (a < int'(o)); mAcc = 4'(r); mZ = (r == 0); end
            4'h4: begin mAcc = mAcc & o; mZ = (mAcc == 0); end
            4'h5: begin mAcc = mAcc | o; mZ = (mAcc == 0); end
            4'h6: begin mAcc = mAcc ^ o; mZ = (mAcc == 0); end
            4'h7: begin mAcc = ~mAcc;    mZ = (mAcc == 0); end
            4'h8: begin mAcc = d;        mZ = (d == 0); end
            4'h9: mOut = mAcc;
            4'hA: begin mC = (a < int'(o)); mZ = (a == int'(o)); end
            4'hB, 4'hC, 4'hD: begin
                mTaken = (i == 4'hB) || (i == 4'hC && mZ) || (i == 4'hD && mC);
                mHi = o; mMode = 1;
            end
            4'hF: begin mMode = 2; mInc = 0; end
            default: ;
        endcase
    endtask

    // One clock of stimulus; returns 1 ns after the rising edge.
    task automatic drive(input bit v, input logic [7:0] b, input logic [3:0] d);
        inValid = v; instr = b[7:4]; oprnd = b[3:0]; dataIn = d;
        @(posedge clk);
        modelStep(v, b[7:4], b[3:0], d);
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        drive(1, 8'h17, 0);
        drive(1, 8'h90, 0);
        drive(1, 8'h29, 0);
        reset = 1'b0;
        #1;
        modelReset();
        checks++;
        if (obsVec() !== 25'h0) begin
            failures++; $display("FAIL reset_async: got %h exp %h", obsVec(), 25'h0);
        end
        drive(1, 8'h1F, 4'h3);
        checks++;
        if (obsVec() !== 25'h0) begin
            failures++; $display("FAIL reset_held: got %h exp %h", obsVec(), 25'h0);
        end
        releaseReset();
    endtask

    task automatic test_basic();
        drive(1, 8'h15, 0);
        checks++;
        if (acc !== 4'h5 || pcInc !== 1'b1 || pcLoad !== 1'b0 || obsVec() !== expVec()) begin
            failures++; $display("FAIL lit5: got acc=%h inc=%b exp acc=5 inc=1", acc, pcInc);
        end
        drive(1, 8'h2A, 0);
        checks++;
        if (acc !== 4'hF || carry !== 1'b0 || zero !== 1'b0 || pcInc !== 1'b1) begin
            failures++;
            $display("FAIL add_a: got acc=%h c=%b z=%b inc=%b exp F 0 0 1", acc, carry, zero, pcInc);
        end
        drive(0, 8'h1E, 0);
        checks++;
        if (pcInc !== 1'b0 || acc !== 4'hF || obsVec() !== expVec()) begin
            failures++; $display("FAIL idle_hold: got %h exp %h", obsVec(), expVec());
        end
    endtask

    task automatic test_wrap();
        drive(1, 8'h1F, 0);
        drive(1, 8'h21, 0);
        checks++;
        if (acc !== 4'h0 || carry !== 1'b1 || zero !== 1'b1) begin
            failures++; $display("FAIL add_wrap: got acc=%h c=%b z=%b exp 0 1 1", acc, carry, zero);
        end
        drive(1, 8'h31, 0);
        checks++;
        if (acc !== 4'hF || carry !== 1'b1 || zero !== 1'b0) begin
            failures++; $display("FAIL sub_wrap: got acc=%h c=%b z=%b exp F 1 0", acc, carry, zero);
        end
    endtask

    task automatic test_jz(input logic [3:0] lit, input bit expTaken);
        drive(1, {4'h1, lit}, 0);
        drive(1, 8'hC3, 0);
        checks++;
        if (pcInc !== 1'b1 || pcLoad !== 1'b0 || acc !== lit) begin
            failures++; $display("FAIL jz_byte1: got inc=%b load=%b acc=%h exp 1 0 %h", pcInc, pcLoad, acc, lit);
        end
        drive(1, 8'h4B, 0);
        checks++;
        if (pcTarget !== 12'h34B || pcLoad !== expTaken || pcInc !== !expTaken || acc !== lit ||
            zero !== (lit == 0)) begin
            failures++;
            $display("FAIL jz_byte2: got tgt=%h load=%b inc=%b acc=%h exp 34b %b %b %h",
                     pcTarget, pcLoad, pcInc, acc, expTaken, !expTaken, lit);
        end
    endtask

    task automatic test_gap();
        drive(1, 8'hB1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'($urandom), 4'($urandom));
            checks++;
            if (pcInc !== 1'b0 || pcLoad !== 1'b0 || obsVec() !== expVec()) begin
                failures++; $display("FAIL gap_%0d: got %h exp %h", k, obsVec(), expVec());
            end
        end
        drive(1, 8'h23, 0);
        checks++;
        if (pcLoad !== 1'b1 || pcInc !== 1'b0 || pcTarget !== 12'h123) begin
            failures++; $display("FAIL gap_jump: got load=%b inc=%b tgt=%h exp 1 0 123", pcLoad, pcInc, pcTarget);
        end
    endtask

    task automatic test_halt();
        drive(1, 8'h16, 0);
        drive(1, 8'hF0, 0);
        checks++;
        if (halt !== 1'b1 || pcInc !== 1'b0 || pcLoad !== 1'b0) begin
            failures++; $display("FAIL halt_enter: got halt=%b inc=%b load=%b exp 1 0 0", halt, pcInc, pcLoad);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 8'h1A + 8'(k * 8'h10), 4'h9);
            checks++;
            if (halt !== 1'b1 || pcInc !== 1'b0 || pcLoad !== 1'b0 || acc !== 4'h6) begin
                failures++; $display("FAIL halt_frozen_%0d: got %h exp %h", k, obsVec(), expVec());
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obsVec() !== 25'h0) begin
            failures++; $display("FAIL halt_reset: got %h exp %h", obsVec(), 25'h0);
        end
        releaseReset();
        drive(1, 8'h13, 0);
        checks++;
        if (acc !== 4'h3 || pcInc !== 1'b1 || halt !== 1'b0) begin
            failures++; $display("FAIL post_halt_exec: got acc=%h inc=%b halt=%b exp 3 1 0", acc, pcInc, halt);
        end
        drive(1, 8'hB1, 0);
        reset = 1'b0;
        #1;
        checks++;
        if (obsVec() !== 25'h0) begin
            failures++; $display("FAIL addr_reset: got %h exp %h", obsVec(), 25'h0);
        end
        releaseReset();
        drive(1, 8'h12, 0);
        checks++;
        if (acc !== 4'h2 || pcInc !== 1'b1 || pcLoad !== 1'b0 || pcTarget !== 12'h000) begin
            failures++; $display("FAIL post_addr_exec: got acc=%h inc=%b load=%b tgt=%h exp 2 1 0 000",
                                 acc, pcInc, pcLoad, pcTarget);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int n = 0; n < 600; n++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'hE;
            drive($urandom_range(0, 3) != 0, b, 4'($urandom));
            checks++;
            if (obsVec() !== expVec() || (pcInc && pcLoad)) begin
                failures++; $display("FAIL random_%0d: got %h exp %h", n, obsVec(), expVec());
            end
            if (mMode == 2 && $urandom_range(0, 3) == 0) begin
                reset = 1'b0;
                #1;
                modelReset();
                checks++;
                if (obsVec() !== expVec()) begin
                    failures++; $display("FAIL random_reset_%0d: got %h exp %h", n, obsVec(), expVec());
                end
                releaseReset();
            end
        end
    endtask

    initial begin
        reset = 1'b0; inValid = 1'b0; instr = 4'h0; oprnd = 4'h0; dataIn = 4'h0;
        modelReset();
        repeat (2) @(posedge clk);
        releaseReset();
        test_reset();
        test_basic();
        test_wrap();
        test_jz(4'h0, 1'b1);
        test_jz(4'h1, 1'b0);
        test_gap();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_exec.md
NIBBLE_EXEC -- requirements
Module: nibble_exec

Interface
REQ-001 The module SHALL have port `clk`: input, 1 bit, single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port `reset`: input, 1 bit, asynchronous, active-low; `reset`=0 forces the reset state immediately.
REQ-003 The module SHALL have port `instr`: input, 4 bits, upper nibble of the byte from the fetch stage.
REQ-004 The module SHALL have port `oprnd`: input, 4 bits, lower nibble of the byte from the fetch stage.
REQ-005 The module SHALL have port `in_valid`: input, 1 bit; high means `{instr,oprnd}` is a new byte to consume this edge.
REQ-006 The module SHALL have port `data_in`: input, 4 bits, external input port read by IN.
REQ-007 The module SHALL have port `acc`: output, 4 bits, accumulator (registered).
REQ-008 The module SHALL have port `carry`: output, 1 bit, carry/borrow flag (registered).
REQ-009 The module SHALL have port `zero`: output, 1 bit, zero flag (registered).
REQ-010 The module SHALL have port `data_out`: output, 4 bits, output port register written by OUT.
REQ-011 The module SHALL have port `pc_inc`: output, 1 bit, one-cycle pulse telling the program counter to advance.
REQ-012 The module SHALL have port `pc_load`: output, 1 bit, one-cycle pulse telling the program counter to load `pc_target`.
REQ-013 The module SHALL have port `pc_target`: output, 12 bits, jump address (registered).
REQ-014 The module SHALL have port `halt`: output, 1 bit, high while in HALT state.

Function
REQ-015 The FSM SHALL have states EXEC, ADDR and HALT; on an edge with `in_valid`=0, state, acc, flags and data_out SHALL hold and pc_inc/pc_load SHALL be 0 next cycle.
REQ-016 In EXEC with `in_valid`=1, the byte SHALL be decoded by `instr`:
  - 0 NOP, E NOP
  - 1 LIT: acc=oprnd
  - 2 ADD: {carry,acc}=acc+oprnd
  - 3 SUB: acc=acc-oprnd mod 16, carry=1 iff acc<oprnd
  - 4 AND, 5 OR, 6 XOR: acc=acc op oprnd
  - 7 NOT: acc=~acc
  - 8 IN: acc=data_in
  - 9 OUT: data_out=acc
  - A CMP: flags as SUB, acc unchanged
  - B JMP, C JZ, D JC
  - F HLT
REQ-017 `zero` SHALL update to (result==0) on opcodes 1-8 and A; `carry` SHALL update only on 2, 3 and A; all other opcodes SHALL leave flags unchanged.
REQ-018 For a consumed non-jump, non-HLT byte, `pc_inc` SHALL be 1 for exactly the cycle after the consuming edge, with acc, flags and data_out updated on that same edge.
REQ-019 B/C/D in EXEC SHALL latch oprnd as target[11:8], latch taken = (B) or (C and zero==1) or (D and carry==1) using flags before the edge, pulse `pc_inc`, and enter ADDR.
REQ-020 In ADDR with `in_valid`=1, the byte SHALL be captured as target[7:0], `pc_target` SHALL become the full 12-bit target, and the state SHALL return to EXEC.
REQ-021 On the ADDR consuming edge, a taken jump SHALL give `pc_load`=1 and `pc_inc`=0 for one cycle; a not-taken jump SHALL give `pc_inc`=1 and `pc_load`=0, with `pc_target` still updated.
REQ-022 The second jump byte SHALL never be executed as an instruction and SHALL NOT change acc or flags.
REQ-023 `pc_inc` and `pc_load` SHALL never be high in the same cycle.
REQ-024 F in EXEC SHALL enter HALT with `pc_inc`=0; in HALT, `halt`=1, all inputs SHALL be ignored, and only reset SHALL exit.
REQ-025 ADD/SUB wrap-around SHALL be modulo 16: F+1 gives acc=0, carry=1, zero=1; 0-1 gives acc=F, carry=1, zero=0.

Reset
REQ-026 While `reset`=0: state=EXEC, acc=0, carry=0, zero=0, data_out=0, pc_inc=0, pc_load=0, pc_target=0, halt=0, latched target/taken=0.
REQ-027 Reset asserted in ADDR or HALT SHALL abandon the pending jump or halt with no pc_load pulse after release.
REQ-028 The first edge after release SHALL behave as EXEC.

Verification
REQ-029 The bench SHALL run: reset, then bytes 0x15, 0x2A with in_valid=1 → acc=5, then acc=F, carry=0, zero=0, one pc_inc pulse per byte.
REQ-030 The bench SHALL run: LIT F, ADD 1 → acc=0, carry=1, zero=1; then SUB 1 → acc=F, carry=1, zero=0.
REQ-031 The bench SHALL run: LIT 0 (zero=1), then bytes 0xC3, 0x4B → pc_inc pulse after first byte, pc_load pulse after second, pc_target=0x34B, acc unchanged.
REQ-032 The bench SHALL run: LIT 1 (zero=0), bytes 0xC3, 0x4B → pc_target=0x34B, two pc_inc pulses, no pc_load.
REQ-033 The bench SHALL run: in_valid=0 gaps between 0xB1 and its second byte → state held in ADDR, no pulses during the gap, jump completes on the next valid byte.
REQ-034 The bench SHALL run: byte 0xF0 then further valid bytes → halt=1, no pc_inc/pc_load, acc frozen; reset low mid-ADDR → all outputs 0 immediately.
